serial_alu_sequencer: RTL and testbench

Bit-serial operand sequencer placed directly upstream of the 1-bit ALU slice, which it also consumes downstream.
- Accepts two WIDTH-bit operands and a 2-bit command through a valid/ready handshake.
- Drives the ALU one bit per clock, LSB first, and holds the carry between bits.
- Assembles the WIDTH-bit result and presents it through a second valid/ready handshake.

---
 rtl/serial_alu_sequencer_if.sv | 45 ++++
 rtl/serial_alu_sequencer.sv | 120 ++++++++++++
 tb/tb_serial_alu_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_sequencer_if.sv
// rtl/serial_alu_sequencer_if.sv - operand, ALU-slice and result bundle for the bit-serial sequencer
//
// Signal groups (directions given from the sequencer's side, modport slave):
//   operand handshake : IN_VALID(in)  IN_READY(out)  IN_A/IN_B[WIDTH](in)  IN_COMMAND[0:1](in)
//   ALU slice         : ALU_A/ALU_B(out)  ALU_COMMAND[0:1](out)  ALU_RES/ALU_CARRY(in)
//   result handshake  : OUT_VALID(out)  OUT_READY(in)  RESULT[WIDTH](out)  CARRY_OUT(out)
//   optional          : ZERO(out), present only with SERIAL_ALU_ZERO_FLAG_EN defined
// The master modport is the environment view: operand source, ALU slice and result sink.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic [0:1]       IN_COMMAND;
    logic             ALU_A;
    logic             ALU_B;
    logic [0:1]       ALU_COMMAND;
    logic             ALU_RES;
    logic             ALU_CARRY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY_OUT;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             ZERO;
`endif

    modport slave (
        input  IN_VALID, IN_A, IN_B, IN_COMMAND, ALU_RES, ALU_CARRY, OUT_READY,
        output IN_READY, ALU_A, ALU_B, ALU_COMMAND, OUT_VALID, RESULT, CARRY_OUT
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        , output ZERO
`endif
    );

    modport master (
        output IN_VALID, IN_A, IN_B, IN_COMMAND, ALU_RES, ALU_CARRY, OUT_READY,
        input  IN_READY, ALU_A, ALU_B, ALU_COMMAND, OUT_VALID, RESULT, CARRY_OUT
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        , input ZERO
`endif
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// rtl/serial_alu_sequencer.sv - bit-serial operand sequencer driving an external 1-bit ALU slice
//
// Ports:
//   CLK     : system clock, all state on the rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : serial_alu_sequencer_if.slave (operand handshake, ALU slice, result handshake)
// Optional feature macro: SERIAL_ALU_ZERO_FLAG_EN adds bus.ZERO (final result == 0, qualified by OUT_VALID).
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    serial_alu_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [0:1] CMD_SUM = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [0:1]       cmd_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready;
    logic             out_valid;
    logic             res_bit;
    logic [WIDTH-1:0] result_next;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zero_q;
`endif

    // The slice is a half adder for SUM; folding in carry_q here turns it
    // into a full adder without needing a carry input on the slice.
    assign res_bit     = (cmd_q == CMD_SUM) ? (bus.ALU_RES ^ carry_q) : bus.ALU_RES;
    assign result_next = {res_bit, result_q[WIDTH-1:1]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.IN_VALID) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == LAST_BIT) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        a_q     <= bus.IN_A;
                        b_q     <= bus.IN_B;
                        cmd_q   <= bus.IN_COMMAND;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    result_q <= result_next;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cmd_q == CMD_SUM) begin
                        carry_q <= bus.ALU_CARRY | (bus.ALU_RES & carry_q);
                    end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    if (cnt_q == LAST_BIT) zero_q <= (result_next == '0);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.OUT_VALID   = out_valid;
    assign bus.ALU_A       = (state_q == RUN) ? a_q[0] : 1'b0;
    assign bus.ALU_B       = (state_q == RUN) ? b_q[0] : 1'b0;
    assign bus.ALU_COMMAND = cmd_q;
    assign bus.RESULT      = result_q;
    assign bus.CARRY_OUT   = carry_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    assign bus.ZERO        = out_valid & zero_q;
`endif
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb/tb_serial_alu_sequencer.sv - self-checking bench for serial_alu_sequencer with a 1-bit ALU slice model
module tb_serial_alu_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer_if #(.WIDTH(W)) bus ();

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // 1-bit ALU slice: NOT_B, OR, AND, and a half adder for SUM.
    assign bus.ALU_RES   = (bus.ALU_COMMAND == 2'b00) ? ~bus.ALU_B :
                           (bus.ALU_COMMAND == 2'b01) ? (bus.ALU_A | bus.ALU_B) :
                           (bus.ALU_COMMAND == 2'b10) ? (bus.ALU_A & bus.ALU_B) :
                                                        (bus.ALU_A ^ bus.ALU_B);
    assign bus.ALU_CARRY = (bus.ALU_COMMAND == 2'b11) ? (bus.ALU_A & bus.ALU_B) : 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, not a bit loop.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] cmd,
                          output logic [W-1:0] res, output logic carry);
        int unsigned s;
        s = 32'(a) + 32'(b);
        carry = 1'b0;
        case (cmd)
            2'b00: res = ~b;
            2'b01: res = a | b;
            2'b10: res = a & b;
            default: begin
                res   = s[W-1:0];
                carry = s[W];
            end
        endcase
    endtask

    task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
        cyc = 0;
        while (bus.OUT_VALID !== 1'b1 && cyc < 60) begin
            if (cyc < W) begin
                check("alu_a_bit", bus.ALU_A, a[cyc]);
                check("alu_b_bit", bus.ALU_B, b[cyc]);
            end
            check("in_ready_run", bus.IN_READY, 0);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] cmd,
                          input int hold, input logic [W-1:0] er, input logic ec);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", bus.IN_READY, 1);
        bus.IN_VALID   = 1'b1;
        bus.IN_A       = a;
        bus.IN_B       = b;
        bus.IN_COMMAND = cmd;
        @(posedge clk);
        @(negedge clk);
        bus.IN_VALID   = 1'b0;
        bus.IN_A       = W'($urandom);
        bus.IN_B       = W'($urandom);
        bus.IN_COMMAND = 2'($urandom);
        wait_done(a, b, cyc);
        check("latency", cyc, W);
        for (int h = 0; h <= hold; h++) begin
            check("out_valid", bus.OUT_VALID, 1);
            check("result", bus.RESULT, er);
            check("carry_out", bus.CARRY_OUT, ec);
            check("in_ready_done", bus.IN_READY, 0);
            check("alu_a_done", bus.ALU_A, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            check("zero", bus.ZERO, (er == 0));
`endif
            if (h < hold) @(negedge clk);
        end
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        bus.OUT_READY = 1'b0;
        check("out_valid_drop", bus.OUT_VALID, 0);
        check("in_ready_back", bus.IN_READY, 1);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        check("zero_unqualified", bus.ZERO, 0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.IN_READY, 1);
        check({tag, "_out_valid"}, bus.OUT_VALID, 0);
        check({tag, "_result"}, bus.RESULT, 0);
        check({tag, "_carry"}, bus.CARRY_OUT, 0);
        check({tag, "_alu_a"}, bus.ALU_A, 0);
        check({tag, "_alu_b"}, bus.ALU_B, 0);
        check({tag, "_alu_cmd"}, bus.ALU_COMMAND, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        check({tag, "_zero"}, bus.ZERO, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic [1:0]   rc;
        logic         ec;
        int           cyc;
        int           t_acc1;
        int           t_acc2;

        bus.IN_VALID   = 1'b0;
        bus.IN_A       = '0;
        bus.IN_B       = '0;
        bus.IN_COMMAND = 2'b00;
        bus.OUT_READY  = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no valid: nothing moves for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_in_ready", bus.IN_READY, 1);
            check("idle_out_valid", bus.OUT_VALID, 0);
            check("idle_alu_a", bus.ALU_A, 0);
            check("idle_alu_b", bus.ALU_B, 0);
        end

        // Directed vectors for each command.
        run_op(8'hB5, 8'h6C, 2'b11, 0, 8'h21, 1'b1);
        run_op(8'hB5, 8'h6C, 2'b10, 0, 8'h24, 1'b0);
        run_op(8'hB5, 8'h6C, 2'b01, 0, 8'hFD, 1'b0);
        run_op(8'hB5, 8'h6C, 2'b00, 0, 8'h93, 1'b0);

        // Wrap to zero with carry, held under 5 cycles of backpressure.
        run_op(8'hFF, 8'h01, 2'b11, 5, 8'h00, 1'b1);

        // Reset pulse in the middle of a SUM.
        @(negedge clk);
        bus.IN_VALID   = 1'b1;
        bus.IN_A       = 8'h0F;
        bus.IN_B       = 8'h0F;
        bus.IN_COMMAND = 2'b11;
        @(posedge clk);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_busy", bus.IN_READY, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_held");
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 2'b11, 0, 8'h03, 1'b0);

        // Back-to-back with IN_VALID held high and OUT_READY held high.
        @(negedge clk);
        bus.OUT_READY  = 1'b1;
        bus.IN_VALID   = 1'b1;
        bus.IN_A       = 8'h10;
        bus.IN_B       = 8'h20;
        bus.IN_COMMAND = 2'b11;
        @(posedge clk);
        t_acc1 = 0;
        @(negedge clk);
        bus.IN_A       = 8'hAA;
        bus.IN_B       = 8'h0F;
        bus.IN_COMMAND = 2'b10;
        wait_done(8'h10, 8'h20, cyc);
        check("b2b_latency1", cyc, W);
        check("b2b_result1", bus.RESULT, 8'h30);
        check("b2b_carry1", bus.CARRY_OUT, 0);
        check("b2b_no_accept_done", bus.IN_READY, 0);
        @(negedge clk);
        check("b2b_idle_ready", bus.IN_READY, 1);
        check("b2b_idle_valid", bus.OUT_VALID, 0);
        t_acc2 = cyc + 2;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        check("b2b_second_accepted", bus.IN_READY, 0);
        check("b2b_issue_interval", t_acc2 - t_acc1, W + 2);
        wait_done(8'hAA, 8'h0F, cyc);
        check("b2b_latency2", cyc, W);
        check("b2b_result2", bus.RESULT, 8'h0A);
        check("b2b_carry2", bus.CARRY_OUT, 0);
        @(negedge clk);
        bus.OUT_READY = 1'b0;
        check("b2b_end_idle", bus.IN_READY, 1);

        // Random operands and commands against the word-level model.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 2'($urandom);
            if (i % 6 == 0) rb = ~ra + W'(1);
            ref_op(ra, rb, rc, er, ec);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), er, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
